// File: rtl/bsg_dll_calib_ctrl_if.sv
// Handshake/bus bundle between the DLL calibration controller and its
// environment (requester, divider and delay line).
interface bsg_dll_calib_ctrl_if #(
  parameter int count_width_p = 8,
  parameter int code_width_p  = 4
);
  logic                     start_i;
  logic [count_width_p-1:0] target_i;
  logic [count_width_p-1:0] count_i;
  logic                     dly_reset_o;
  logic                     div_clear_o;
  logic                     div_enable_o;
  logic [code_width_p-1:0]  code_o;
  logic                     locked_o;
  logic                     busy_o;
  logic                     error_o;

  // Environment side: issues requests and returns the divider count.
  modport master (
    output start_i, target_i, count_i,
    input  dly_reset_o, div_clear_o, div_enable_o, code_o,
           locked_o, busy_o, error_o
  );

  // Controller side.
  modport slave (
    input  start_i, target_i, count_i,
    output dly_reset_o, div_clear_o, div_enable_o, code_o,
           locked_o, busy_o, error_o
  );
endinterface

// File: rtl/bsg_dll_calib_ctrl.sv
// DLL calibration controller: steps the delay-line code until the divider
// period count lands within tol_p of the target, or gives up.
// Optional feature macro: BSG_DLL_CALIB_TRACK_EN (continuous re-measurement
// while locked). Without it, LOCK is terminal until start_i or reset.
module bsg_dll_calib_ctrl #(
  parameter int count_width_p   = 8,
  parameter int code_width_p    = 4,
  parameter int init_code_p     = 8,
  parameter int settle_cycles_p = 4,
  parameter int meas_cycles_p   = 64,
  parameter int tol_p           = 1
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_dll_calib_ctrl_if.slave   bus
);

  localparam int max_cycles_lp = (meas_cycles_p > settle_cycles_p) ? meas_cycles_p : settle_cycles_p;
  localparam int cnt_width_lp  = $clog2(max_cycles_lp) + 1;
  localparam int iter_width_lp = code_width_p + 1;
  localparam int cmp_width_lp  = count_width_p + 1;

  localparam logic [cnt_width_lp-1:0]  settle_last_lp = cnt_width_lp'(settle_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0]  meas_last_lp   = cnt_width_lp'(meas_cycles_p - 1);
  localparam logic [iter_width_lp-1:0] iter_limit_lp  = iter_width_lp'((1 << code_width_p) + 1);
  localparam logic [cmp_width_lp-1:0]  tol_lp         = cmp_width_lp'(tol_p);
  localparam logic [code_width_p-1:0]  code_max_lp    = '1;

  typedef enum logic [2:0] {IDLE, RST, CLR, MEAS, CMP, LOCK, FAIL} state_e;

  state_e                   state_reg, state_next;
  logic [cnt_width_lp-1:0]  cnt_reg,   cnt_next;
  logic [iter_width_lp-1:0] iter_reg,  iter_next;
  logic [code_width_p-1:0]  code_reg,  code_next;
  logic                     track_reg, track_next;

  // One extra bit of headroom so target +/- tol never wraps; the low bound
  // is tested as count + tol < target to avoid subtracting below zero.
  logic [cmp_width_lp-1:0] count_ext, target_ext;
  logic                    too_high, too_low;

  assign count_ext  = {1'b0, bus.count_i};
  assign target_ext = {1'b0, bus.target_i};
  assign too_high   = count_ext > (target_ext + tol_lp);
  assign too_low    = (count_ext + tol_lp) < target_ext;

  // State and datapath registers; reset aborts any calibration in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      iter_reg  <= '0;
      code_reg  <= code_width_p'(init_code_p);
      track_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iter_reg  <= iter_next;
      code_reg  <= code_next;
      track_reg <= track_next;
    end
  end

  // Next-state logic; the code register moves only on CMP -> RST.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    iter_next  = iter_reg;
    code_next  = code_reg;
    track_next = track_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          state_next = RST;
          cnt_next   = '0;
          iter_next  = '0;
        end
      end
      RST: begin
        if (cnt_reg == settle_last_lp) begin
          state_next = CLR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CLR: begin
        state_next = MEAS;
        cnt_next   = '0;
      end
      MEAS: begin
        if (cnt_reg == meas_last_lp) begin
          state_next = CMP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CMP: begin
        iter_next  = iter_reg + 1'b1;
        track_next = 1'b0;
        if (!too_high && !too_low) begin
          // Re-arm the iteration limit every time lock is reached.
          state_next = LOCK;
          iter_next  = '0;
          track_next = track_reg;
        end else if (iter_next == iter_limit_lp) begin
          state_next = FAIL;
        end else if (too_high) begin
          if (code_reg == '0) begin
            state_next = FAIL;
          end else begin
            state_next = RST;
            code_next  = code_reg - 1'b1;
          end
        end else begin
          if (code_reg == code_max_lp) begin
            state_next = FAIL;
          end else begin
            state_next = RST;
            code_next  = code_reg + 1'b1;
          end
        end
      end
      LOCK: begin
        if (bus.start_i) begin
          state_next = RST;
          cnt_next   = '0;
          iter_next  = '0;
          track_next = 1'b0;
        end else begin
`ifdef BSG_DLL_CALIB_TRACK_EN
          state_next = CLR;
          track_next = 1'b1;
`else
          state_next = LOCK;
`endif
        end
      end
      FAIL: begin
        if (bus.start_i) begin
          state_next = RST;
          cnt_next   = '0;
          iter_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  assign bus.dly_reset_o  = (state_reg == IDLE) || (state_reg == RST);
  assign bus.div_clear_o  = (state_reg == CLR);
  assign bus.div_enable_o = (state_reg == MEAS);
  assign bus.busy_o       = (state_reg == RST) || (state_reg == CLR) ||
                            (state_reg == MEAS) || (state_reg == CMP);
  assign bus.locked_o     = (state_reg == LOCK) || track_reg;
  assign bus.error_o      = (state_reg == FAIL);
  assign bus.code_o       = code_reg;

endmodule

// File: tb/tb_bsg_dll_calib_ctrl.sv
// Self-checking bench for bsg_dll_calib_ctrl with a divider model of
// count = 10*code + offset. Build with BSG_DLL_CALIB_TRACK_EN for the
// tracking scenario.
module tb_bsg_dll_calib_ctrl;

  localparam int TOL    = 1;
  localparam int ITER   = 4 + 1 + 64 + 1;  // cycles per calibration attempt
  localparam int MAXN   = 17;
  localparam int CODEMX = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   offset = 0;

  bsg_dll_calib_ctrl_if #(.count_width_p(8), .code_width_p(4)) bus ();

  assign bus.count_i = 8'(10 * int'(bus.code_o) + offset);

  bsg_dll_calib_ctrl dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_code = 8;
  int exp_codes[0:MAXN];
  int exp_n;
  bit exp_lock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.dly_reset_o, bus.div_clear_o, bus.div_enable_o, bus.busy_o,
            bus.locked_o, bus.error_o, bus.code_o};
  endfunction

  function automatic logic [9:0] pack(bit dly, bit clr, bit en, bit busy, bit lk, bit er, int code);
    logic [3:0] c;
    c = 4'(code);
    return {dly, clr, en, busy, lk, er, c};
  endfunction

  // Reference: walk the code sequence with plain integer arithmetic.
  task automatic predict(input int code0, input int tgt, input int off);
    int c;
    int cnt;
    c = code0;
    exp_lock = 1'b0;
    exp_n = 0;
    for (int i = 1; i <= MAXN; i++) begin
      exp_codes[i-1] = c;
      exp_n = i;
      cnt = 10 * c + off;
      if (cnt >= tgt - TOL && cnt <= tgt + TOL) begin
        exp_lock = 1'b1;
        break;
      end
      if (i == MAXN) break;
      if (cnt > tgt) begin
        if (c == 0) break;
        c--;
      end else begin
        if (c == CODEMX) break;
        c++;
      end
    end
  endtask

  // One calibration request, checked every cycle against the model's schedule.
  task automatic run_cal(input int tgt, input int term_cycles);
    int k, p, fin;
    predict(model_code, tgt, offset);
    fin = exp_codes[exp_n-1];
    @(negedge clk);
    bus.target_i = 8'(tgt);
    bus.start_i  = 1'b1;
    for (int c = 1; c <= exp_n * ITER; c++) begin
      @(negedge clk);
      bus.start_i = 1'($urandom_range(0, 1));  // must be ignored while busy
      k = (c - 1) / ITER;
      p = (c - 1) % ITER;
      check_eq("cyc", 32'(outs()),
               32'(pack(p < 4, p == 4, p >= 5 && p <= 68, 1'b1, 1'b0, 1'b0, exp_codes[k])));
    end
    bus.start_i = 1'b0;
    for (int t = 0; t < term_cycles; t++) begin
      if (t > 0) @(negedge clk);
      else #0;
      if (t == 0) @(negedge clk);
      check_eq("term", 32'(outs()), 32'(pack(0, 0, 0, 0, exp_lock, !exp_lock, fin)));
    end
    $display("run target=%0d offset=%0d start_code=%0d cmps=%0d result=%s code=%0d",
             tgt, offset, model_code, exp_n, exp_lock ? "locked" : "error", fin);
    model_code = fin;
  endtask

  // Reset asserted mid-MEAS must force reset outputs without a clock edge.
  task automatic reset_mid_meas(input int tgt);
    predict(model_code, tgt, offset);
    @(negedge clk);
    bus.target_i = 8'(tgt);
    bus.start_i  = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    check_eq("pre_rst_meas", 32'(bus.div_enable_o), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_eq("rst_async", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 0, 8)));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 0, 8)));
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("idle_after", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 0, 8)));
    end
    $display("run reset mid-MEAS target=%0d -> idle code=8", tgt);
    model_code = 8;
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.target_i = '0;
    repeat (3) @(negedge clk);
    check_eq("reset", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 0, 8)));
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 0, 8)));

`ifdef BSG_DLL_CALIB_TRACK_EN
    begin
      int i;
      run_cal(80, 1);
      offset = 20;
      for (i = 0; i < 300; i++) begin
        @(negedge clk);
        if (!bus.locked_o) break;
      end
      check_eq("trk_drop", 32'(bus.locked_o), 32'd0);
      check_eq("trk_code7", 32'(bus.code_o), 32'd7);
      for (i = 0; i < 400; i++) begin
        @(negedge clk);
        if (bus.locked_o) break;
      end
      check_eq("trk_relock", 32'(bus.locked_o), 32'd1);
      check_eq("trk_code6", 32'(bus.code_o), 32'd6);
      $display("run tracking offset=20 relock code=%0d", bus.code_o);
    end
`else
    run_cal(80, 3);   // lock immediately at code 8
    run_cal(50, 3);   // 8,7,6,5
    run_cal(200, 3);  // climbs to 15 then fails
    reset_mid_meas(120);
    run_cal(55, 3);   // oscillation, fails on the 17th compare
    run_cal(0, 3);    // low bound must not wrap
    run_cal(255, 3);  // high bound must not wrap
    run_cal(82, 3);   // just outside tolerance
    run_cal(81, 3);   // just inside tolerance
    repeat (8) begin
      offset = $urandom_range(0, 9);
      run_cal($urandom_range(0, 255), 2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_dll_calib_ctrl.md
BSG_DLL_CALIB_CTRL -- requirements
Module: bsg_dll_calib_ctrl

Interface
REQ-001 Parameter count_width_p, default 8: width of the divider period count and target.
REQ-002 Parameter code_width_p, default 4: width of the delay-line control code.
REQ-003 Parameter init_code_p, default 8: code loaded at reset.
REQ-004 Parameter settle_cycles_p, default 4: cycles the delay line is held in reset after each code change.
REQ-005 Parameter meas_cycles_p, default 64: length of the measurement window in cycles.
REQ-006 Parameter tol_p, default 1: lock tolerance, |count - target| <= tol_p.
REQ-007 clk_i  in  1  single clock for the whole block.
REQ-008 reset_n_i  in  1  reset, asynchronous and active-low.
REQ-009 start_i  in  1  calibration request, level-sampled.
REQ-010 target_i  in  count_width_p  desired period count; held stable while busy_o is high.
REQ-011 count_i  in  count_width_p  period count from the divider, valid in CMP.
REQ-012 dly_reset_o  out  1  delay-line reset.
REQ-013 div_clear_o  out  1  divider synchronous clear.
REQ-014 div_enable_o  out  1  divider count enable.
REQ-015 code_o  out  code_width_p  delay-line control code.
REQ-016 locked_o  out  1  count is within tolerance.
REQ-017 busy_o  out  1  calibration in progress.
REQ-018 error_o  out  1  calibration failed.

Function
REQ-019 The FSM SHALL have states IDLE, RST, CLR, MEAS, CMP, LOCK and FAIL.
REQ-020 IDLE: if start_i=1, go to RST next cycle and clear the iteration counter.
REQ-021 RST: dly_reset_o=1 for exactly settle_cycles_p cycles, then go to CLR.
REQ-022 CLR: div_clear_o=1 for one cycle, then go to MEAS.
REQ-023 MEAS: div_enable_o=1 for exactly meas_cycles_p cycles, then go to CMP.
REQ-024 CMP (one cycle): sample count_i and increment the iteration counter. Outcomes:
- Within tolerance: go to LOCK.
- count_i > target_i+tol_p: code_o-1, go to RST.
- count_i < target_i-tol_p: code_o+1, go to RST.
REQ-025 The comparison SHALL be unsigned at count_width_p+1 bits, so target_i±tol_p does not wrap.
REQ-026 If a required step would take code_o past 0 or past 2^code_width_p-1, the FSM SHALL go to FAIL and leave code_o unchanged.
REQ-027 If the iteration counter reaches 2^code_width_p+1 without lock, the FSM SHALL go to FAIL.
REQ-028 busy_o=1 in RST, CLR, MEAS and CMP; start_i is ignored in those states.
REQ-029 locked_o=1 in LOCK only; error_o=1 in FAIL only.
REQ-030 LOCK/FAIL with start_i=1: go to RST from the current code_o, clear the iteration counter, drop locked_o and error_o.
REQ-031 dly_reset_o SHALL also be 1 in IDLE and 0 in every other state not listed above.
REQ-032 code_o SHALL change only on the CMP→RST transition.

Reset
REQ-033 While reset_n_i=0, the block SHALL immediately enter IDLE with these output values:
- code_o = init_code_p.
- dly_reset_o = 1.
- div_clear_o, div_enable_o, locked_o, busy_o, error_o = 0.
REQ-034 Reset asserted mid-operation SHALL abort calibration with no further divider pulses; the first state after deassertion is IDLE.

Configuration
REQ-035 Macro BSG_DLL_CALIB_TRACK_EN controls behaviour in LOCK:
- Defined: LOCK re-runs CLR→MEAS→CMP continuously with locked_o held high. An out-of-tolerance CMP steps the code per REQ-024 and drops locked_o. The iteration limit is re-armed at each lock.
- Undefined: LOCK is terminal until start_i or reset; div_enable_o=0 in LOCK.

Verification
REQ-036 Bench model: count_i = 10*code_o. Scenario: target_i=80, start_i pulsed at cycle 0 → RST cycles 1-4, div_clear_o cycle 5, div_enable_o cycles 6-69, CMP cycle 70, locked_o=1 from cycle 71, code_o=8.
REQ-037 target_i=50 → code_o steps 8,7,6,5 → locked_o=1 after the 4th CMP with code_o=5.
REQ-038 target_i=200 → code_o climbs to 15 → FAIL with error_o=1 and code_o=15.
REQ-039 target_i=55, tol_p=1 (oscillates between codes 5 and 6) → FAIL after the 17th CMP with error_o=1.
REQ-040 reset_n_i driven low mid-MEAS → all outputs at REQ-033 values in the same cycle; FSM in IDLE after release.
REQ-041 With BSG_DLL_CALIB_TRACK_EN defined, lock at target_i=80, then change the model to 10*code_o+20 → locked_o drops, code_o steps 8→7→6, locked_o reasserts at code_o=6.
